// File: rtl/pwm_capture_if.sv
`default_nettype none
// ============================================================================
// pwm_capture_if : processor-side result/acknowledge bundle of pwm_capture
// rev 1.0
// ============================================================================
interface pwm_capture_if;
    logic        le;
    logic [31:0] dutyCicleOut;
    logic [31:0] periodoOut;
    logic        valido;
    logic        novo;
    logic        perdido;

    modport master (
        output le,
        input  dutyCicleOut,
        input  periodoOut,
        input  valido,
        input  novo,
        input  perdido
    );

    modport slave (
        input  le,
        output dutyCicleOut,
        output periodoOut,
        output valido,
        output novo,
        output perdido
    );
endinterface
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// pwm_capture : measures high time and period of an asynchronous PWM input
// rev 1.0
// ============================================================================
module pwm_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16,
    parameter int TIMEOUT     = 1000,
    parameter int HIGH_VALUE  = 101
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         sinal,
    pwm_capture_if.slave bus
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_MEAS   = 2'd1;
    localparam logic [1:0] ST_STATIC = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [31:0]      DUTY_HIGH   = 32'(HIGH_VALUE);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_prev_q;
    logic                   w_s;
    logic                   w_rise;
    logic                   w_timeout;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] high_q;
    logic [CNT_W-1:0] high_d;
    logic [CNT_W-1:0] per_q;
    logic [CNT_W-1:0] per_d;

    logic        w_pub;
    logic [31:0] w_pub_duty;
    logic [31:0] w_pub_per;

    logic [31:0] duty_q;
    logic [31:0] duty_d;
    logic [31:0] period_q;
    logic [31:0] period_d;
    logic        valido_q;
    logic        novo_q;
    logic        novo_d;
    logic        perdido_q;
    logic        perdido_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q   <= '0;
            s_prev_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], sinal};
            s_prev_q <= w_s;
        end
    end

    assign w_s       = sync_q[SYNC_STAGES-1];
    assign w_rise    = w_s & ~s_prev_q;
    assign w_timeout = ~w_rise & (per_q == CNT_TIMEOUT);

    // A rise always takes precedence over a timeout hitting in the same cycle,
    // so a period of exactly TIMEOUT ticks is still reported normally.
    always_comb begin
        state_d    = state_q;
        high_d     = high_q;
        per_d      = per_q;
        w_pub      = 1'b0;
        w_pub_duty = '0;
        w_pub_per  = '0;
        case (state_q)
            ST_IDLE: begin
                if (w_rise) begin
                    high_d  = CNT_ONE;
                    per_d   = CNT_ONE;
                    state_d = ST_MEAS;
                end else if (w_timeout) begin
                    w_pub      = 1'b1;
                    w_pub_duty = w_s ? DUTY_HIGH : 32'd0;
                    state_d    = ST_STATIC;
                end else begin
                    per_d = per_q + CNT_ONE;
                end
            end
            ST_MEAS: begin
                if (w_rise) begin
                    w_pub      = 1'b1;
                    w_pub_duty = 32'(high_q);
                    w_pub_per  = 32'(per_q);
                    high_d     = CNT_ONE;
                    per_d      = CNT_ONE;
                end else if (w_timeout) begin
                    w_pub      = 1'b1;
                    w_pub_duty = w_s ? DUTY_HIGH : 32'd0;
                    state_d    = ST_STATIC;
                end else begin
                    per_d  = per_q + CNT_ONE;
                    high_d = high_q + {{(CNT_W-1){1'b0}}, w_s};
                end
            end
            ST_STATIC: begin
                if (w_rise) begin
                    high_d  = CNT_ONE;
                    per_d   = CNT_ONE;
                    state_d = ST_MEAS;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A publish coinciding with an acknowledge leaves only the new result pending.
    always_comb begin
        duty_d    = w_pub ? w_pub_duty : duty_q;
        period_d  = w_pub ? w_pub_per  : period_q;
        novo_d    = novo_q;
        perdido_d = perdido_q;
        if (w_pub) begin
            novo_d    = 1'b1;
            perdido_d = bus.le ? 1'b0 : (perdido_q | novo_q);
        end else if (bus.le) begin
            novo_d    = 1'b0;
            perdido_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            high_q    <= '0;
            per_q     <= '0;
            duty_q    <= '0;
            period_q  <= '0;
            valido_q  <= 1'b0;
            novo_q    <= 1'b0;
            perdido_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            high_q    <= high_d;
            per_q     <= per_d;
            duty_q    <= duty_d;
            period_q  <= period_d;
            valido_q  <= w_pub;
            novo_q    <= novo_d;
            perdido_q <= perdido_d;
        end
    end

    assign bus.dutyCicleOut = duty_q;
    assign bus.periodoOut   = period_q;
    assign bus.valido       = valido_q;
    assign bus.novo         = novo_q;
    assign bus.perdido      = perdido_q;

endmodule
`default_nettype wire
